// File: rtl/pipe_share_sched.sv
// Round-robin scheduler sharing one fixed-latency, valid-only pipeline among NUM_REQ requesters.
// Optional checks are compiled in with `define PIPE_SHARE_ASSERT_EN.
module pipe_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 1,
  parameter int PIPE_LAT   = 2,
  parameter int RST_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_pred,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pipe_rst,
  output logic                      pipe_input_valid,
  output logic                      pipe_pred,
  output logic [DATA_W-1:0]         pipe_x,
  input  logic                      pipe_output_valid,
  input  logic [DATA_W-1:0]         pipe_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      idle
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(PIPE_LAT + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    IDLE     = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [RC_W-1:0]   rst_cnt_r;
  logic [ID_W-1:0]   ptr_r;
  logic [PIPE_LAT-1:0] tag_vld_r;
  logic [ID_W-1:0]   tag_id_r [PIPE_LAT];
  logic [CNT_W-1:0]  cnt_r;

  logic              found_s;
  logic              grant_s;
  logic [ID_W-1:0]   gnt_id_s;
  logic [ID_W:0]     idx_s;
  logic              tail_vld_s;
  logic [ID_W-1:0]   tail_id_s;

  // Round-robin search starting at the pointer, wrapping at NUM_REQ
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
        idx_s = idx_s - (ID_W+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
        found_s  = 1'b1;
        gnt_id_s = idx_s[ID_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign grant_s    = (state_r == RUN) && enable && found_s;
  assign tail_vld_s = tag_vld_r[PIPE_LAT-1];
  assign tail_id_s  = tag_id_r[PIPE_LAT-1];

  // Grant strobe and pipeline input mux
  always_comb begin
    req_ready        = '0;
    pipe_input_valid = 1'b0;
    pipe_pred        = 1'b0;
    pipe_x           = '0;
    if (grant_s) begin
      req_ready[gnt_id_s] = 1'b1;
      pipe_input_valid    = 1'b1;
      pipe_pred           = req_pred[gnt_id_s];
      pipe_x              = req_x[gnt_id_s*DATA_W +: DATA_W];
    end else begin
      req_ready = '0;
    end
  end

  // Result routing; outputs without a matching tag are dropped
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pipe_output_valid && tail_vld_s) begin
      rsp_valid[tail_id_s] = 1'b1;
      rsp_data             = pipe_out;
    end else begin
      rsp_data = '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RST_HOLD: begin
        if (rst_cnt_r == RC_W'(RST_CYCLES - 1)) begin
          state_nxt_s = enable ? RUN : IDLE;
        end else begin
          state_nxt_s = RST_HOLD;
        end
      end
      RUN: begin
        if (!enable) state_nxt_s = DRAIN;
        else         state_nxt_s = RUN;
      end
      DRAIN: begin
        if (cnt_r == '0) state_nxt_s = IDLE;
        else             state_nxt_s = DRAIN;
      end
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      default: state_nxt_s = RST_HOLD;
    endcase
  end

  // State, reset-hold counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RST_HOLD;
      rst_cnt_r <= '0;
      ptr_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == RST_HOLD) rst_cnt_r <= rst_cnt_r + RC_W'(1);
      if (grant_s) begin
        ptr_r <= (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
      end
    end
  end

  // Ownership tags travel alongside the pipeline; in-flight counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_id_r[i] <= '0;
      cnt_r <= '0;
    end else begin
      for (int i = PIPE_LAT - 1; i >= 1; i--) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
      tag_vld_r[0] <= grant_s;
      tag_id_r[0]  <= gnt_id_s;
      case ({grant_s, tail_vld_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign pipe_rst = (state_r == RST_HOLD);
  assign busy     = (cnt_r != '0) | pipe_rst;
  assign idle     = (state_r == IDLE);

`ifdef PIPE_SHARE_ASSERT_EN
  pipe_share_sched_chk #(
    .NUM_REQ (NUM_REQ),
    .PIPE_LAT(PIPE_LAT),
    .CNT_W   (CNT_W)
  ) u_chk (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_rst         (pipe_rst),
    .pipe_output_valid(pipe_output_valid),
    .tail_vld         (tail_vld_s),
    .req_ready        (req_ready),
    .cnt              (cnt_r)
  );
`endif

endmodule

`ifdef PIPE_SHARE_ASSERT_EN
`ifndef BR_ASSERT
`define BR_ASSERT(name, expr) name : assert property (@(posedge clk) disable iff (!rst_n) (expr));
`endif
module pipe_share_sched_chk #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic               pipe_rst,
  input logic               pipe_output_valid,
  input logic               tail_vld,
  input logic [NUM_REQ-1:0] req_ready,
  input logic [CNT_W-1:0]   cnt
);
  `BR_ASSERT(out_matches_tag, pipe_rst || (pipe_output_valid == tail_vld))
  `BR_ASSERT(ready_onehot0, $onehot0(req_ready))
  `BR_ASSERT(cnt_bound, cnt <= CNT_W'(PIPE_LAT))
  `BR_ASSERT(no_grant_in_rst, !pipe_rst || (req_ready == '0))
endmodule
`endif

// File: tb/tb_pipe_share_sched.sv
// Directed bench for pipe_share_sched with a queue scoreboard and a 2-cycle pipeline model returning x.
module tb_pipe_share_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req_valid, req_pred, req_x;
  logic [3:0] req_ready;
  logic       pipe_rst, pipe_input_valid, pipe_pred;
  logic [0:0] pipe_x;
  logic       pipe_output_valid;
  logic [0:0] pipe_out;
  logic [3:0] rsp_valid;
  logic [0:0] rsp_data;
  logic       busy, idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   id;
    logic d;
    int   due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [1:0] mv = 2'b00;
  logic [1:0] mx = 2'b00;
  logic       inject = 1'b0;

  pipe_share_sched #(.NUM_REQ(4), .DATA_W(1), .PIPE_LAT(2), .RST_CYCLES(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .req_valid        (req_valid),
    .req_pred         (req_pred),
    .req_x            (req_x),
    .req_ready        (req_ready),
    .pipe_rst         (pipe_rst),
    .pipe_input_valid (pipe_input_valid),
    .pipe_pred        (pipe_pred),
    .pipe_x           (pipe_x),
    .pipe_output_valid(pipe_output_valid),
    .pipe_out         (pipe_out),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pipeline model: latency 2, out = x, synchronous reset
  always @(posedge clk) begin
    if (pipe_rst) begin
      mv <= 2'b00;
      mx <= 2'b00;
    end else begin
      mv <= {mv[0], pipe_input_valid};
      mx <= {mx[0], pipe_x[0]};
    end
  end
  assign pipe_output_valid = mv[1] | inject;
  assign pipe_out          = mx[1];

  // Monitor: each response must match the oldest expected entry
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (rsp_valid != 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual rsp_valid=%b data=%b required none at cyc %0d", rsp_valid, rsp_data, cyc);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== 4'(1 << e.id) || rsp_data[0] !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL rsp actual valid=%b data=%b cyc=%0d required valid=%b data=%b cyc=%0d",
                   rsp_valid, rsp_data, cyc, 4'(1 << e.id), e.d, e.due);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b cyc=%0d", n, act, exp, cyc);
    end
  endtask

  // One cycle: drive, check at the falling edge, queue the expected response
  task automatic step(input logic [3:0] v, input logic [3:0] x, input logic [3:0] p,
                      input int exp_id, input int exp_busy, input int exp_idle, input logic exp_prst);
    logic [3:0] exp_rdy;
    req_valid = v;
    req_x     = x;
    req_pred  = p;
    @(negedge clk);
    exp_rdy = (exp_id >= 0) ? 4'(1 << exp_id) : 4'b0000;
    chk("req_ready", req_ready, exp_rdy);
    chk("pipe_input_valid", {3'b000, pipe_input_valid}, {3'b000, exp_id >= 0});
    if (exp_id >= 0) begin
      chk("pipe_x", {3'b000, pipe_x[0]}, {3'b000, x[exp_id]});
      chk("pipe_pred", {3'b000, pipe_pred}, {3'b000, p[exp_id]});
      sb.push_back('{exp_id, x[exp_id], cyc + 2});
    end
    chk("pipe_rst", {3'b000, pipe_rst}, {3'b000, exp_prst});
    if (exp_busy >= 0) chk("busy", {3'b000, busy}, {3'b000, exp_busy[0]});
    if (exp_idle >= 0) chk("idle", {3'b000, idle}, {3'b000, exp_idle[0]});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_req_ready"}, req_ready, 4'b0000);
    chk({n, "_rsp_valid"}, rsp_valid, 4'b0000);
    chk({n, "_piv"}, {3'b000, pipe_input_valid}, 4'b0000);
    chk({n, "_pipe_x"}, {2'b00, pipe_pred, pipe_x[0]}, 4'b0000);
    chk({n, "_pipe_rst"}, {3'b000, pipe_rst}, 4'b0001);
    chk({n, "_idle"}, {3'b000, idle}, 4'b0000);
  endtask

  logic [3:0] xs [8] = '{4'b0101, 4'b0011, 4'b1100, 4'b1010, 4'b0110, 4'b1001, 4'b1111, 4'b0001};

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'hF;
    req_pred  = 4'h0;
    req_x     = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pipe_rst held for three edges, no grants even with all requests up
    for (int i = 0; i < 3; i++) step(4'hF, 4'h0, 4'h0, -1, 1, 0, 1'b1);

    // Round-robin over all requesters; first grant goes to 0
    for (int i = 0; i < 8; i++) step(4'hF, xs[i], ~xs[i], i % 4, -1, 0, 1'b0);

    // Move pointer to 2, then only 3 and 1 request: 3, 1, 3
    step(4'hF, 4'b0001, 4'h0, 0, -1, 0, 1'b0);
    step(4'hF, 4'b0010, 4'h0, 1, -1, 0, 1'b0);
    step(4'b1010, 4'hF, 4'h0, 3, -1, 0, 1'b0);
    step(4'b1010, 4'hF, 4'h0, 1, -1, 0, 1'b0);
    step(4'b1010, 4'hF, 4'h0, 3, -1, 0, 1'b0);

    // Drain with two in flight
    step(4'hF, 4'b0011, 4'h0, 0, -1, 0, 1'b0);
    step(4'hF, 4'b0011, 4'h0, 1, -1, 0, 1'b0);
    enable = 1'b0;
    step(4'hF, 4'h0, 4'h0, -1, 1, 0, 1'b0);
    step(4'hF, 4'h0, 4'h0, -1, 1, 0, 1'b0);
    step(4'hF, 4'h0, 4'h0, -1, 0, 0, 1'b0);
    step(4'hF, 4'h0, 4'h0, -1, 0, 1, 1'b0);
    enable = 1'b1;
    step(4'hF, 4'h0, 4'h0, -1, 0, 1, 1'b0);
    step(4'hF, 4'b0100, 4'h0, 2, -1, 0, 1'b0);
    step(4'hF, 4'b1000, 4'h0, 3, -1, 0, 1'b0);

    // Asynchronous reset with two results in flight: they must vanish
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'hF, 4'h0, 4'h0, -1, 1, 0, 1'b1);
    step(4'hF, 4'h0, 4'h0, -1, 1, 0, 1'b1);
    step(4'hF, 4'b0001, 4'h0, 0, -1, 0, 1'b0);

    // Spurious pipeline output with no tag in flight
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, -1, -1, 0, 1'b0);
    inject = 1'b1;
    @(negedge clk);
    chk("rsp_spurious", rsp_valid, 4'b0000);
    @(posedge clk);
    #1;
    inject = 1'b0;
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, -1, 0, 0, 1'b0);

    chk("sb_empty", 4'(sb.size()), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
